// File: rtl/RAM_2Port.sv
// Simple dual-port RAM with a registered read port. The contents and the
// read-side registers are not reset.
module RAM_2Port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     i_Wr_Clk,
  input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Rd_Clk,
  input  logic [$clog2(DEPTH)-1:0] i_Rd_Addr,
  input  logic                     i_Rd_En,
  output logic                     o_Rd_DV,
  output logic [WIDTH-1:0]         o_Rd_Data
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  // Write port: store data on a write strobe
  always_ff @(posedge i_Wr_Clk) begin
    if (i_Wr_DV) begin
      r_mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // Read port: one-cycle registered read, valid follows the enable
  always_ff @(posedge i_Rd_Clk) begin
    o_Rd_DV <= i_Rd_En;
    if (i_Rd_En) begin
      o_Rd_Data <= r_mem[i_Rd_Addr];
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller around RAM_2Port. Pointers wrap explicitly at
// DEPTH-1, so DEPTH need not be a power of two. Flags are decoded from the
// registered count; rejected accesses leave all state untouched and raise a
// one-cycle error pulse.
module ram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_Wr_DV,
  input  logic [WIDTH-1:0]           i_Wr_Data,
  input  logic                       i_Rd_En,
  output logic                       o_Rd_DV,
  output logic [WIDTH-1:0]           o_Rd_Data,
  output logic [$clog2(DEPTH+1)-1:0] o_Count,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic                       o_AF,
  output logic                       o_AE,
  output logic                       o_Wr_Err,
  output logic                       o_Rd_Err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_rd_dv;
  logic             r_wr_err;
  logic             r_rd_err;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_ram_data;
  logic             w_unused_ram_dv;

  function automatic logic [AW-1:0] f_next_ptr(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + AW'(1);
  endfunction

  // Acceptance uses the flags as they stood before the edge
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = i_Wr_DV & ~w_full;
  assign w_rd_acc = i_Rd_En & ~w_empty;

  // Pointer advance on accepted accesses, wrapping at DEPTH-1
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= f_next_ptr(r_rd_ptr);
    end
  end

  // Occupancy: +1 write only, -1 read only, unchanged otherwise
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-valid and error pulses; the valid is our own resettable copy so a
  // read in flight at reset never produces a strobe afterwards
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rd_dv  <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_rd_dv  <= w_rd_acc;
      r_wr_err <= i_Wr_DV & w_full;
      r_rd_err <= i_Rd_En & w_empty;
    end
  end

  RAM_2Port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .i_Wr_Clk  (i_Clk),
    .i_Wr_Addr (r_wr_ptr),
    .i_Wr_DV   (w_wr_acc),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_Clk  (i_Clk),
    .i_Rd_Addr (r_rd_ptr),
    .i_Rd_En   (w_rd_acc),
    .o_Rd_DV   (w_unused_ram_dv),
    .o_Rd_Data (w_ram_data)
  );

  // RAM output register is unreset; mask it so data reads as zero in reset
  assign o_Rd_Data = r_rd_dv ? w_ram_data : '0;
  assign o_Rd_DV   = r_rd_dv;
  assign o_Count   = r_count;
  assign o_Full    = w_full;
  assign o_Empty   = w_empty;
  assign o_AF      = (r_count >= AF_CNT);
  assign o_AE      = (r_count <= AE_CNT);
  assign o_Wr_Err  = r_wr_err;
  assign o_Rd_Err  = r_rd_err;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl at WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_dv;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       rd_dv;
  logic [7:0] rd_data;
  logic [2:0] cnt;
  logic       full, empty, af, ae, wr_err, rd_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Wr_DV   (wr_dv),
    .i_Wr_Data (wr_data),
    .i_Rd_En   (rd_en),
    .o_Rd_DV   (rd_dv),
    .o_Rd_Data (rd_data),
    .o_Count   (cnt),
    .o_Full    (full),
    .o_Empty   (empty),
    .o_AF      (af),
    .o_AE      (ae),
    .o_Wr_Err  (wr_err),
    .o_Rd_Err  (rd_err)
  );

  // advance one rising edge and settle 1 ns past it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      wr_dv = 1'b1; wr_data = base + 8'(i); cyc();
    end
    wr_dv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_dv = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    repeat (2) cyc();
    total++; if (cnt !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    total++; if ({full, empty, af, ae} !== 4'b0101) begin bad++; $display("FAIL reset_flags got=%b exp=0101", {full, empty, af, ae}); end
    total++; if ({rd_dv, wr_err, rd_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {rd_dv, wr_err, rd_err}); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wr_dv = 1'b1; wr_data = d[i]; cyc();
      total++; if (cnt !== 3'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, cnt, i + 1); end
      total++; if ({full, empty, af, ae} !== {(i == 3), 1'b0, (i >= 2), (i == 0)})
        begin bad++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {full, empty, af, ae}, {(i == 3), 1'b0, (i >= 2), (i == 0)}); end
    end
    wr_dv = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (rd_dv !== 1'b1 || rd_data !== d[i]) begin bad++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, rd_dv, rd_data, d[i]); end
      total++; if (cnt !== 3'(3 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, cnt, 3 - i); end
    end
    rd_en = 1'b0; cyc();
    total++; if (rd_dv !== 1'b0 || empty !== 1'b1 || ae !== 1'b1) begin bad++; $display("FAIL drain_end got dv=%b empty=%b ae=%b exp 0/1/1", rd_dv, empty, ae); end
  endtask

  task automatic test_overflow();
    fill(8'hB1);
    wr_dv = 1'b1; wr_data = 8'h55; cyc();
    total++; if (wr_err !== 1'b1 || cnt !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL ovf_pulse got err=%b cnt=%0d full=%b exp 1/4/1", wr_err, cnt, full); end
    wr_dv = 1'b0; cyc();
    total++; if (wr_err !== 1'b0 || cnt !== 3'd4) begin bad++; $display("FAIL ovf_clear got err=%b cnt=%0d exp 0/4", wr_err, cnt); end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (rd_dv !== 1'b1 || rd_data !== 8'hB1 + 8'(i)) begin bad++; $display("FAIL ovf_drain i=%0d got=%b/%h exp=1/%h", i, rd_dv, rd_data, 8'hB1 + 8'(i)); end
    end
    rd_en = 1'b0; cyc();
    total++; if (rd_dv !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL ovf_no_55 got dv=%b data=%h empty=%b exp 0/-/1", rd_dv, rd_data, empty); end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1; cyc();
    total++; if (rd_err !== 1'b1 || rd_dv !== 1'b0 || cnt !== 3'd0) begin bad++; $display("FAIL udf_pulse got err=%b dv=%b cnt=%0d exp 1/0/0", rd_err, rd_dv, cnt); end
    rd_en = 1'b0; cyc();
    total++; if (rd_err !== 1'b0 || rd_dv !== 1'b0) begin bad++; $display("FAIL udf_clear got err=%b dv=%b exp 0/0", rd_err, rd_dv); end
  endtask

  task automatic test_back_to_back();
    wr_dv = 1'b1; wr_data = 8'h01; cyc();
    wr_data = 8'h02; cyc();
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h03 + 8'(i); cyc();
      total++; if (rd_dv !== 1'b1 || rd_data !== 8'h01 + 8'(i)) begin bad++; $display("FAIL b2b_data i=%0d got=%b/%h exp=1/%h", i, rd_dv, rd_data, 8'h01 + 8'(i)); end
      total++; if (cnt !== 3'd2 || wr_err !== 1'b0 || rd_err !== 1'b0) begin bad++; $display("FAIL b2b_state i=%0d got cnt=%0d we=%b re=%b exp 2/0/0", i, cnt, wr_err, rd_err); end
    end
    wr_dv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if (rd_dv !== 1'b1 || rd_data !== 8'h07 + 8'(i) || cnt !== 3'(1 - i)) begin bad++; $display("FAIL b2b_tail i=%0d got=%b/%h cnt=%0d exp=1/%h cnt=%0d", i, rd_dv, rd_data, cnt, 8'h07 + 8'(i), 1 - i); end
    end
    rd_en = 1'b0; cyc();
  endtask

  task automatic test_full_rw();
    fill(8'h61);
    wr_dv = 1'b1; wr_data = 8'h65; rd_en = 1'b1; cyc();
    total++; if (wr_err !== 1'b1 || rd_err !== 1'b0) begin bad++; $display("FAIL frw_err got we=%b re=%b exp 1/0", wr_err, rd_err); end
    total++; if (rd_dv !== 1'b1 || rd_data !== 8'h61 || cnt !== 3'd3) begin bad++; $display("FAIL frw_read got=%b/%h cnt=%0d exp=1/61 cnt=3", rd_dv, rd_data, cnt); end
    wr_dv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (rd_dv !== 1'b1 || rd_data !== 8'h62 + 8'(i)) begin bad++; $display("FAIL frw_drain i=%0d got=%b/%h exp=1/%h", i, rd_dv, rd_data, 8'h62 + 8'(i)); end
    end
    rd_en = 1'b0; cyc();
    total++; if (rd_dv !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL frw_end got dv=%b empty=%b exp 0/1", rd_dv, empty); end
  endtask

  task automatic test_reset_inflight();
    wr_dv = 1'b1; wr_data = 8'h77; cyc();
    wr_dv = 1'b0; rd_en = 1'b1; cyc();
    total++; if (rd_dv !== 1'b1 || rd_data !== 8'h77) begin bad++; $display("FAIL rif_read got=%b/%h exp=1/77", rd_dv, rd_data); end
    rd_en = 1'b0; wr_dv = 1'b1; wr_data = 8'h99; cnt_check_pre: begin end
    rst_n = 1'b0; #1;
    total++; if (rd_dv !== 1'b0 || rd_data !== 8'h00) begin bad++; $display("FAIL rif_async got=%b/%h exp=0/00", rd_dv, rd_data); end
    wr_dv = 1'b0;
    repeat (2) cyc();
    total++; if ({full, empty, af, ae} !== 4'b0101 || cnt !== 3'd0 || {wr_err, rd_err} !== 2'b00)
      begin bad++; $display("FAIL rif_flags got=%b cnt=%0d err=%b exp=0101 cnt=0 err=00", {full, empty, af, ae}, cnt, {wr_err, rd_err}); end
    rst_n = 1'b1;
    wr_dv = 1'b1; wr_data = 8'hA5; cyc();
    total++; if (cnt !== 3'd1 || rd_dv !== 1'b0) begin bad++; $display("FAIL rif_first_wr got cnt=%0d dv=%b exp 1/0", cnt, rd_dv); end
    wr_dv = 1'b0; rd_en = 1'b1; cyc();
    total++; if (rd_dv !== 1'b1 || rd_data !== 8'hA5 || cnt !== 3'd0) begin bad++; $display("FAIL rif_a5 got=%b/%h cnt=%0d exp=1/a5 cnt=0", rd_dv, rd_data, cnt); end
    rd_en = 1'b0; cyc();
    total++; if (rd_dv !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL rif_end got dv=%b empty=%b exp 0/1", rd_dv, empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_full_rw();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
